bit_serializer: RTL

//   Parallel-to-serial stage directly upstream of the 1010 Moore sequence detector.

---
 rtl/seq_pkg.sv | 15 +
 rtl/mod_counter.sv | 44 ++++
 rtl/bit_serializer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the serializer and the downstream 1010 sequence detector.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Load/enable counter over 0..N-1; counts up or down and holds at its terminal value.
module mod_counter
  import seq_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter bit          DOWN = 1'b0,
  localparam int unsigned W   = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt = cnt_q;

  // Clear wins over load, load wins over enable; no wrap past either end.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (DOWN) begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end else begin
        if (cnt_q != W'(N - 1)) cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 1010 detector: valid/ready word in, one bit per clk out.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0,
  parameter bit          IDLE_BIT  = 1'b0,
  localparam int unsigned CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam bit          NO_GAP = (GAP == 0);
  localparam int unsigned GAP_N  = NO_GAP ? 1 : GAP;
  localparam int unsigned GAP_W  = cnt_w(GAP_N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shift;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             busy_q, busy_d;

  logic             bit_clr, bit_en;
  logic             gap_load, gap_en;
  logic [GAP_W-1:0] gap_cnt;
  logic             bit_last, gap_done, accept;

  mod_counter #(.N(WIDTH), .DOWN(1'b0)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (bit_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (bit_en),
    .cnt      (bit_cnt)
  );

  // Loaded with GAP-1 so the GAP state lasts exactly GAP cycles.
  mod_counter #(.N(GAP_N), .DOWN(1'b1)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (1'b0),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_N - 1)),
    .en       (gap_en),
    .cnt      (gap_cnt)
  );

  assign bit_last = (bit_cnt == CNT_W'(WIDTH - 1));
  assign gap_done = (gap_cnt == '0);
  assign in_ready = (state_q == S_IDLE) || (NO_GAP && (state_q == S_SHIFT) && bit_last);
  assign accept   = in_valid && in_ready;

  assign shreg_shift = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_clr  = 1'b0;
    bit_en   = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          shreg_d = in_data;
          bit_clr = 1'b1;
        end
      end
      S_SHIFT: begin
        if (!bit_last) begin
          shreg_d = shreg_shift;
          bit_en  = 1'b1;
        end else begin
          bit_clr = 1'b1;
          if (!NO_GAP) begin
            state_d  = S_GAP;
            gap_load = 1'b1;
          end else if (accept) begin
            shreg_d = in_data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_done) state_d = S_IDLE;
        else          gap_en  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they line up with bit_cnt after the edge.
  always_comb begin
    sout_d        = IDLE_BIT;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    busy_d        = (state_d != S_IDLE);
    if (state_d == S_SHIFT) begin
      sout_d        = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
      sout_valid_d  = 1'b1;
      frame_start_d = bit_clr;
      frame_end_d   = bit_en && (bit_cnt == CNT_W'(WIDTH - 2));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      sout_q        <= IDLE_BIT;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = busy_q;

endmodule
